// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and constants for the RV32M multiply/divide unit
package muldiv_pkg;

    // RV32M funct3 encodings; bit 2 separates divide (1) from multiply (0),
    // and bit 1 within the divide group selects remainder.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } md_state_e;

    localparam int ITERS = 32;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, shared shift-add / restoring-subtract datapath
//
// Ports:
//   clk     in   core clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   request strobe, sampled only in IDLE
//   funct3  in   RV32M op select
//   a, b    in   rs1 / rs2 operands, latched on accept
//   busy    out  high while iterating
//   done    out  one-cycle result-valid pulse
//   result  out  registered result, held until the next accepted op
//
// Optional: MULDIV_EARLY_OUT_EN adds zero-operand multiply and |a|<|b|
// divide fast paths.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       r_state, w_next_state;
    md_op_e          r_op;
    logic            r_neg_a, r_neg_b;
    logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_result;
    logic [CW-1:0]   r_cnt;

    // ---- accept-time decode -------------------------------------------
    md_op_e          w_op;
    logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_fast;
    logic [XLEN-1:0] w_spec_res;

    assign w_op     = md_op_e'(funct3);
    assign w_is_div = funct3[2];
    assign w_sgn_a  = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_sgn_b  = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_neg_a  = w_sgn_a & a[XLEN-1];
    assign w_neg_b  = w_sgn_b & b[XLEN-1];
    assign w_mag_a  = w_neg_a ? (~a + 1'b1) : a;
    assign w_mag_b  = w_neg_b ? (~b + 1'b1) : b;

    always_comb begin
        w_fast     = 1'b0;
        w_spec_res = '0;
        if (w_is_div && (b == '0)) begin
            w_fast     = 1'b1;
            w_spec_res = funct3[1] ? a : '1;
        end else if (((w_op == MD_DIV) || (w_op == MD_REM)) && (a == SMIN) && (b == '1)) begin
            w_fast     = 1'b1;
            w_spec_res = funct3[1] ? '0 : SMIN;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (!w_is_div && ((a == '0) || (b == '0))) begin
            w_fast     = 1'b1;
            w_spec_res = '0;
        end else if (w_is_div && (w_mag_a < w_mag_b)) begin
            w_fast     = 1'b1;
            w_spec_res = funct3[1] ? a : '0;
`endif
        end
    end

    // ---- one iteration -------------------------------------------------
    // Multiply: {r_hi,r_lo} is the product/multiplier pair shifted right
    // each step. Divide: r_hi is the partial remainder, r_lo shifts the
    // dividend out at the top and the quotient bits in at the bottom.
    logic [XLEN:0]   w_sum, w_trial;
    logic            w_ok;
    logic [XLEN-1:0] w_nxt_hi, w_nxt_lo;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opnd};
        w_ok    = ~w_trial[XLEN];
        if (r_op[2]) begin
            w_nxt_hi = w_ok ? w_trial[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_nxt_lo = {r_lo[XLEN-2:0], w_ok};
        end else begin
            w_nxt_hi = w_sum[XLEN:1];
            w_nxt_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ---- sign correction on the final iteration -----------------------
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fin_res;

    always_comb begin
        w_prod    = {w_nxt_hi, w_nxt_lo};
        w_prod_s  = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
        w_quo     = (r_neg_a ^ r_neg_b) ? (~w_nxt_lo + 1'b1) : w_nxt_lo;
        w_rem     = r_neg_a ? (~w_nxt_hi + 1'b1) : w_nxt_hi;
        w_fin_res = '0;
        case (r_op)
            MD_MUL:                        w_fin_res = w_prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  w_fin_res = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               w_fin_res = w_quo;
            MD_REM, MD_REMU:               w_fin_res = w_rem;
            default:                       w_fin_res = '0;
        endcase
    end

    // ---- control FSM ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = w_fast ? S_FIN : S_RUN;
            S_RUN:   if (r_cnt == CW'(ITERS - 1)) w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_FIN);
    assign result = r_result;

    // ---- datapath registers --------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= MD_MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= w_op;
                    r_neg_a <= w_neg_a;
                    r_neg_b <= w_neg_b;
                    r_cnt   <= '0;
                    r_hi    <= '0;
                    if (w_fast) begin
                        r_result <= w_spec_res;
                    end else if (w_is_div) begin
                        r_lo   <= w_mag_a;
                        r_opnd <= w_mag_b;
                    end else begin
                        r_lo   <= w_mag_b;
                        r_opnd <= w_mag_a;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_nxt_hi;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITERS - 1)) r_result <= w_fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] prev_res = '0;

    localparam logic [31:0] SMIN = 32'h8000_0000;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout global bound reached");
        $fatal(1, "global timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the RV32M rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (op)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                q = sx / sy;
                return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                q = sx % sy;
                return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        bit f;
        longint mx, my;
        f = op[2] && ((y == 0) || (((op == 3'd4) || (op == 3'd6)) && (x == SMIN) && (y == 32'hFFFF_FFFF)));
`ifdef MULDIV_EARLY_OUT_EN
        if ((op == 3'd4) || (op == 3'd6)) begin
            mx = longint'($signed(x)); if (mx < 0) mx = -mx;
            my = longint'($signed(y)); if (my < 0) my = -my;
        end else begin
            mx = longint'({32'b0, x});
            my = longint'({32'b0, y});
        end
        if (!op[2] && ((x == 0) || (y == 0))) f = 1'b1;
        if (op[2] && (y != 0) && (mx < my)) f = 1'b1;
`else
        mx = 0; my = 0;
`endif
        return f;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] opa, input logic [31:0] opb, input logic [31:0] exp_res);
        bit fast;
        int cyc_done, busy_cnt;
        logic [31:0] res_at_done;
        fast = is_fast(op, opa, opb);
        cyc_done = 0; busy_cnt = 0; res_at_done = '0;
        @(negedge clk);
        start = 1'b1; funct3 = op; a = opa; b = opb;
        for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin cyc_done = c; res_at_done = result; end
            if (c == 1) begin
                if (!fast) check_eq("hold_before_done", result, prev_res);
                start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
            end
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end
        check_eq("latency", 32'(cyc_done), fast ? 32'd1 : 32'd33);
        check_eq("busy_cycles", 32'(busy_cnt), fast ? 32'd0 : 32'd32);
        check_eq("result", res_at_done, exp_res);
        start = 1'b1; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        check_eq("fin_start_ignored", {30'b0, busy, done}, 32'd0);
        check_eq("result_held", result, exp_res);
        prev_res = exp_res;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return SMIN;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct { logic [2:0] op; logic [31:0] x, y, r; } vec_t;
    vec_t dir[$] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd7,         32'd14},
        '{3'd7, 32'd100,        32'd7,         32'd2},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'd5,          32'd0,         32'd5},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{3'd0, 32'd0,          32'h1234,      32'd0},
        '{3'd5, 32'd3,          32'd9,         32'd0}
    };

    initial begin
        int dcnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        check_eq("reset_state", {result[31:2], busy, done}, 32'd0);
        check_eq("reset_result", result, 32'd0);
        reset = 1'b0;

        foreach (dir[i]) do_op(dir[i].op, dir[i].x, dir[i].y, dir[i].r);

        // Abort a divide with reset partway through.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; a = 32'h7FFF_FFFF; b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check_eq("busy_mid_div", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_flags", {30'b0, busy, done}, 32'd0);
        check_eq("abort_result", result, 32'd0);
        reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check_eq("no_done_after_abort", 32'(dcnt), 32'd0);
        prev_res = '0;

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op(rop, ra, rb, model(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
